// File: rtl/flash_port_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of spimemio (read port + cfgreg write path).
// Optional hang watchdog enabled by defining FLASH_ARB_TIMEOUT_EN.
module flash_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        m0_valid_i,
    input  logic [23:0] m0_addr_i,
    output logic        m0_ready_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_valid_i,
    input  logic [23:0] m1_addr_i,
    input  logic [3:0]  m1_cfg_we_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_ready_o,
    output logic [31:0] m1_rdata_o,
    output logic        mem_valid_o,
    output logic [23:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    output logic [3:0]  mem_cfgreg_we_o,
    output logic [31:0] mem_cfgreg_di_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CFG  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;
    logic   last_grant;
    logic   gnt;
    logic   pick1_c;

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] wd_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
    assign err_o = 1'b0;
`endif

    // Port 1 wins if it is the only requester or if port 0 was served last.
    always_comb begin
        pick1_c = 1'b0;
        if (m0_valid_i && m1_valid_i) begin
            pick1_c = ~last_grant;
        end else begin
            pick1_c = m1_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state           <= IDLE;
            last_grant      <= 1'b1;
            gnt             <= 1'b0;
            m0_ready_o      <= 1'b0;
            m0_rdata_o      <= 32'h0;
            m1_ready_o      <= 1'b0;
            m1_rdata_o      <= 32'h0;
            mem_valid_o     <= 1'b0;
            mem_addr_o      <= 24'h0;
            mem_cfgreg_we_o <= 4'h0;
            mem_cfgreg_di_o <= 32'h0;
`ifdef FLASH_ARB_TIMEOUT_EN
            wd_cnt          <= '0;
            err_o           <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid_i || m1_valid_i) begin
                        gnt        <= pick1_c;
                        last_grant <= pick1_c;
                        if (pick1_c && (m1_cfg_we_i != 4'h0)) begin
                            state           <= CFG;
                            mem_cfgreg_we_o <= m1_cfg_we_i;
                            mem_cfgreg_di_o <= m1_wdata_i;
                        end else begin
                            state       <= READ;
                            mem_valid_o <= 1'b1;
                            mem_addr_o  <= pick1_c ? m1_addr_i : m0_addr_i;
`ifdef FLASH_ARB_TIMEOUT_EN
                            wd_cnt      <= '0;
`endif
                        end
                    end
                end
                READ: begin
                    // A ready arriving on the limit cycle still completes normally.
                    if (mem_ready_i) begin
                        mem_valid_o <= 1'b0;
                        state       <= RESP;
                        if (gnt) begin
                            m1_ready_o <= 1'b1;
                            m1_rdata_o <= mem_rdata_i;
                        end else begin
                            m0_ready_o <= 1'b1;
                            m0_rdata_o <= mem_rdata_i;
                        end
                    end
`ifdef FLASH_ARB_TIMEOUT_EN
                    else if (wd_cnt == CNT_LAST) begin
                        mem_valid_o <= 1'b0;
                        err_o       <= 1'b1;
                        state       <= RESP;
                        if (gnt) begin
                            m1_ready_o <= 1'b1;
                            m1_rdata_o <= 32'hFFFF_FFFF;
                        end else begin
                            m0_ready_o <= 1'b1;
                            m0_rdata_o <= 32'hFFFF_FFFF;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
`endif
                end
                CFG: begin
                    mem_cfgreg_we_o <= 4'h0;
                    m1_ready_o      <= 1'b1;
                    m1_rdata_o      <= 32'h0;
                    state           <= RESP;
                end
                RESP: begin
                    m0_ready_o <= 1'b0;
                    m1_ready_o <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_port_arbiter.sv
// Bench for flash_port_arbiter: directed boundary cases, then randomized traffic
// against a scoreboard fed by the requesters and drained by an output monitor.
module tb_flash_port_arbiter;

    typedef struct packed {
        logic        cfg;
        logic [23:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        m0_valid_i;
    logic [23:0] m0_addr_i;
    logic        m0_ready_o;
    logic [31:0] m0_rdata_o;
    logic        m1_valid_i;
    logic [23:0] m1_addr_i;
    logic [3:0]  m1_cfg_we_i;
    logic [31:0] m1_wdata_i;
    logic        m1_ready_o;
    logic [31:0] m1_rdata_o;
    logic        mem_valid_o;
    logic [23:0] mem_addr_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;
    logic [3:0]  mem_cfgreg_we_o;
    logic [31:0] mem_cfgreg_di_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    req_t q0[$];
    req_t q1[$];
    logic        done;
    logic        prev_valid;
    logic [23:0] prev_addr;
    logic [3:0]  prev_we;
    logic        granted[2];
    int          foreign[2];

    flash_port_arbiter #(.TIMEOUT(16)) dut (
        .clk_i(clk),
        .rstn_i(rstn_i),
        .m0_valid_i(m0_valid_i),
        .m0_addr_i(m0_addr_i),
        .m0_ready_o(m0_ready_o),
        .m0_rdata_o(m0_rdata_o),
        .m1_valid_i(m1_valid_i),
        .m1_addr_i(m1_addr_i),
        .m1_cfg_we_i(m1_cfg_we_i),
        .m1_wdata_i(m1_wdata_i),
        .m1_ready_o(m1_ready_o),
        .m1_rdata_o(m1_rdata_o),
        .mem_valid_o(mem_valid_o),
        .mem_addr_o(mem_addr_o),
        .mem_ready_i(mem_ready_i),
        .mem_rdata_i(mem_rdata_i),
        .mem_cfgreg_we_o(mem_cfgreg_we_o),
        .mem_cfgreg_di_o(mem_cfgreg_di_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_data(input logic [23:0] a);
        return {a[7:0], a} ^ 32'h3C5A_96E1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_flags"}, 32'({m0_ready_o, m1_ready_o, mem_valid_o, err_o}), 32'h0);
        check({name, "_m0_rdata"}, m0_rdata_o, 32'h0);
        check({name, "_m1_rdata"}, m1_rdata_o, 32'h0);
        check({name, "_mem_addr"}, 32'(mem_addr_o), 32'h0);
        check({name, "_cfg_we"}, 32'(mem_cfgreg_we_o), 32'h0);
        check({name, "_cfg_di"}, mem_cfgreg_di_o, 32'h0);
    endtask

    // Worst case a waiting port sees exactly one foreign grant before its own.
    task automatic note_grant(input int p);
        int o;
        o = 1 - p;
        checks++;
        if (foreign[p] > 1) begin
            errors++;
            $display("FAIL fairness: port%0d waited through %0d foreign grants, limit 1", p, foreign[p]);
        end
        granted[p] = 1'b1;
        foreign[p] = 0;
        if ((o == 0 ? q0.size() : q1.size()) != 0 && !granted[o]) foreign[o]++;
    endtask

    task automatic monitor_step();
        req_t r;
        if (mem_valid_o && !prev_valid) begin
            if (mem_addr_o[23] ? (q1.size() == 0) : (q0.size() == 0)) begin
                flag("grant_without_request");
            end else begin
                r = mem_addr_o[23] ? q1[0] : q0[0];
                check("grant_is_read", 32'(r.cfg), 32'h0);
                check("grant_addr", 32'(mem_addr_o), 32'(r.addr));
                note_grant(int'(mem_addr_o[23]));
            end
        end
        if (mem_valid_o && prev_valid) check("addr_hold", 32'(mem_addr_o), 32'(prev_addr));
        if (mem_cfgreg_we_o != 4'h0) begin
            check("cfg_no_mem_valid", 32'(mem_valid_o), 32'h0);
            if (prev_we != 4'h0) flag("cfg_we_longer_than_one_cycle");
            else if (q1.size() == 0) flag("cfg_without_request");
            else begin
                r = q1[0];
                check("cfg_is_cfg", 32'(r.cfg), 32'h1);
                check("cfg_we", 32'(mem_cfgreg_we_o), 32'(r.we));
                check("cfg_di", mem_cfgreg_di_o, r.wdata);
                note_grant(1);
            end
        end
        if (m0_ready_o) begin
            check("ready_exclusive", 32'(m1_ready_o), 32'h0);
            if (q0.size() == 0) flag("m0_ready_unexpected");
            else begin
                r = q0.pop_front();
                check("m0_ready_after_grant", 32'(granted[0]), 32'h1);
                check("m0_rdata", m0_rdata_o, r.rdata);
            end
            granted[0] = 1'b0;
            foreign[0] = 0;
        end
        if (m1_ready_o) begin
            if (q1.size() == 0) flag("m1_ready_unexpected");
            else begin
                r = q1.pop_front();
                check("m1_ready_after_grant", 32'(granted[1]), 32'h1);
                check("m1_rdata", m1_rdata_o, r.rdata);
            end
            granted[1] = 1'b0;
            foreign[1] = 0;
        end
        prev_valid = mem_valid_o;
        prev_addr  = mem_addr_o;
        prev_we    = mem_cfgreg_we_o;
    endtask

    task automatic run_port(input int p, input int n);
        req_t r;
        int   t;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            r.cfg   = (p == 1) && ($urandom_range(0, 2) == 0);
            r.addr  = {1'(p), 23'($urandom)};
            r.we    = r.cfg ? 4'($urandom_range(1, 15)) : 4'h0;
            r.wdata = $urandom;
            r.rdata = r.cfg ? 32'h0 : exp_data(r.addr);
            if (p == 0) begin
                m0_addr_i  = r.addr;
                m0_valid_i = 1'b1;
                q0.push_back(r);
            end else begin
                m1_addr_i   = r.addr;
                m1_cfg_we_i = r.we;
                m1_wdata_i  = r.wdata;
                m1_valid_i  = 1'b1;
                q1.push_back(r);
            end
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(p == 0 ? m0_ready_o : m1_ready_o) && t < 200);
            if (!(p == 0 ? m0_ready_o : m1_ready_o)) begin
                checks++;
                errors++;
                $display("FAIL port%0d_ready_wait: no ready after %0d cycles, required within 200", p, t);
            end
            if (p == 0) m0_valid_i = 1'b0;
            else m1_valid_i = 1'b0;
        end
    endtask

    // Flash model: answers within 4 cycles; stray ready pulses while no read is open.
    task automatic mem_model();
        int w = 0;
        while (!done) begin
            @(negedge clk);
            if (mem_valid_o && (w >= 3 || $urandom_range(0, 2) == 0)) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = exp_data(mem_addr_o);
                w = 0;
            end else begin
                if (mem_valid_o) w++;
                mem_ready_i = !mem_valid_o && ($urandom_range(0, 5) == 0);
                mem_rdata_i = $urandom;
            end
        end
        mem_ready_i = 1'b0;
    endtask

    task automatic monitor();
        while (!done) begin
            @(negedge clk);
            monitor_step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: bench did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        rstn_i = 1'b0;
        m0_valid_i = 1'b1; m0_addr_i = 24'h000100;
        m1_valid_i = 1'b1; m1_addr_i = 24'h000200;
        m1_cfg_we_i = 4'h0; m1_wdata_i = 32'h0;
        mem_ready_i = 1'b0; mem_rdata_i = 32'h0;
        done = 1'b0;

        // Reset with both requests pending, then port 0 must win first.
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("reset");
        end
        rstn_i = 1'b1;
        @(negedge clk);
        check("first_grant_valid", 32'(mem_valid_o), 32'h1);
        check("first_grant_addr", 32'(mem_addr_o), 32'h000100);
        @(negedge clk);
        @(negedge clk);
        mem_ready_i = 1'b1; mem_rdata_i = 32'hA5A5_1234;
        @(negedge clk);
        mem_ready_i = 1'b0;
        check("rd0_m0_ready", 32'(m0_ready_o), 32'h1);
        check("rd0_m0_rdata", m0_rdata_o, 32'hA5A5_1234);
        check("rd0_m1_ready", 32'(m1_ready_o), 32'h0);
        check("rd0_mem_valid_drop", 32'(mem_valid_o), 32'h0);
        m0_valid_i = 1'b0;
        @(negedge clk);
        check("rd0_ready_pulse_end", 32'(m0_ready_o), 32'h0);
        @(negedge clk);
        check("rd1_grant_valid", 32'(mem_valid_o), 32'h1);
        check("rd1_grant_addr", 32'(mem_addr_o), 32'h000200);
        mem_ready_i = 1'b1; mem_rdata_i = 32'h1122_3344;
        @(negedge clk);
        mem_ready_i = 1'b0;
        check("rd1_m1_ready", 32'(m1_ready_o), 32'h1);
        check("rd1_m1_rdata", m1_rdata_o, 32'h1122_3344);
        check("rd1_m0_rdata_hold", m0_rdata_o, 32'hA5A5_1234);
        check("rd1_m0_ready", 32'(m0_ready_o), 32'h0);
        m1_valid_i = 1'b0;

        // Config write: one-cycle cfgreg strobe, no read valid.
        @(negedge clk);
        m1_valid_i = 1'b1; m1_cfg_we_i = 4'b1000; m1_wdata_i = 32'h8000_0000;
        @(negedge clk);
        check("cfg_we", 32'(mem_cfgreg_we_o), 32'h8);
        check("cfg_di", mem_cfgreg_di_o, 32'h8000_0000);
        check("cfg_mem_valid", 32'(mem_valid_o), 32'h0);
        check("cfg_early_ready", 32'(m1_ready_o), 32'h0);
        @(negedge clk);
        check("cfg_we_end", 32'(mem_cfgreg_we_o), 32'h0);
        check("cfg_m1_ready", 32'(m1_ready_o), 32'h1);
        check("cfg_m1_rdata", m1_rdata_o, 32'h0);
        check("cfg_mem_valid_resp", 32'(mem_valid_o), 32'h0);
        m1_valid_i = 1'b0; m1_cfg_we_i = 4'h0;
        @(negedge clk);
        check("cfg_ready_pulse_end", 32'(m1_ready_o), 32'h0);

        // Reset in the middle of a port-0 read.
        m0_valid_i = 1'b1; m0_addr_i = 24'h000400;
        @(negedge clk);
        check("midrst_read_open", 32'(mem_valid_o), 32'h1);
        rstn_i = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(mem_valid_o), 32'h0);
        check("midrst_m0_ready", 32'(m0_ready_o), 32'h0);
        check("midrst_m1_rdata", m1_rdata_o, 32'h0);
        rstn_i = 1'b1;
        m1_valid_i = 1'b1; m1_addr_i = 24'h000500;
        @(negedge clk);
        check("midrst_regrant_addr", 32'(mem_addr_o), 32'h000400);
        check("midrst_no_ready", 32'(m0_ready_o), 32'h0);
        mem_ready_i = 1'b1; mem_rdata_i = 32'h0BAD_F00D;
        @(negedge clk);
        mem_ready_i = 1'b0;
        check("midrst_m0_ready", 32'(m0_ready_o), 32'h1);
        check("midrst_m0_rdata", m0_rdata_o, 32'h0BAD_F00D);
        m0_valid_i = 1'b0; m1_valid_i = 1'b0;

`ifdef FLASH_ARB_TIMEOUT_EN
        // Flash never answers: watchdog fires after 16 read cycles.
        @(negedge clk);
        m0_valid_i = 1'b1; m0_addr_i = 24'h000123;
        repeat (16) @(negedge clk);
        check("wd_valid_held", 32'(mem_valid_o), 32'h1);
        check("wd_no_err_yet", 32'(err_o), 32'h0);
        @(negedge clk);
        check("wd_valid_drop", 32'(mem_valid_o), 32'h0);
        check("wd_m0_ready", 32'(m0_ready_o), 32'h1);
        check("wd_m0_rdata", m0_rdata_o, 32'hFFFF_FFFF);
        check("wd_err", 32'(err_o), 32'h1);
        m0_valid_i = 1'b0;
        @(negedge clk);
        check("wd_err_sticky", 32'(err_o), 32'h1);
`endif

        // Randomized contention on both ports.
        prev_valid = 1'b0; prev_addr = 24'h0; prev_we = 4'h0;
        granted[0] = 1'b0; granted[1] = 1'b0;
        foreign[0] = 0; foreign[1] = 0;
        fork
            begin
                fork
                    run_port(0, 40);
                    run_port(1, 40);
                join
                done = 1'b1;
            end
            mem_model();
            monitor();
        join
        check("q0_drained", 32'(q0.size()), 32'h0);
        check("q1_drained", 32'(q1.size()), 32'h0);

        @(negedge clk);
        rstn_i = 1'b0;
        @(negedge clk);
        check_reset_outputs("final_reset");
        rstn_i = 1'b1;
        @(negedge clk);
        check("final_err_clear", 32'(err_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_port_arbiter.md
# flash_port_arbiter

Two-requester arbiter and sequencer in front of the `spimemio` flash controller. Port 0 (instruction fetch) issues read-only requests. Port 1 (data/config) issues either reads or configuration-register writes. The block serializes both onto the single `spimemio` valid/ready read port and its `cfgreg_we`/`cfgreg_di` write path, using round-robin fairness and an optional hang watchdog.

## Interface
- TIMEOUT, 255: watchdog limit in cycles, range 1..255. Used only with FLASH_ARB_TIMEOUT_EN.
- clk_i  in  1  system clock
- rstn_i  in  1  reset; one clock; reset is synchronous and active-low
- m0_valid_i  in  1  port-0 read request; held until m0_ready_o
- m0_addr_i  in  24  port-0 byte address
- m0_ready_o  out  1  one-cycle completion pulse
- m0_rdata_o  out  32  read data, valid with m0_ready_o
- m1_valid_i  in  1  port-1 request; held until m1_ready_o
- m1_addr_i  in  24  port-1 byte address (ignored for config writes)
- m1_cfg_we_i  in  4  byte enables; nonzero means config write, zero means read
- m1_wdata_i  in  32  config write data
- m1_ready_o  out  1  one-cycle completion pulse
- m1_rdata_o  out  32  read data; 0 for config writes
- mem_valid_o  out  1  to spimemio valid
- mem_addr_o  out  24  to spimemio addr
- mem_ready_i  in  1  from spimemio ready
- mem_rdata_i  in  32  from spimemio rdata
- mem_cfgreg_we_o  out  4  to spimemio cfgreg_we
- mem_cfgreg_di_o  out  32  to spimemio cfgreg_di
- err_o  out  1  sticky timeout flag; constant 0 when the watchdog is compiled out

## Operation
- States: IDLE, READ, CFG, RESP. All outputs are registered.
- Reset (rstn_i low at a clk_i edge): state IDLE, last_grant=1 so port 0 wins first. All outputs 0, including rdata, addr, cfg outputs and err_o. Reset mid-transfer abandons the transfer; no ready pulse is issued.
- IDLE: requests sampled every cycle.
  - One valid: that port is granted.
  - Both valid: the port other than last_grant is granted (round-robin).
  - last_grant updates on every grant.
- Grant, read (port 0, or port 1 with m1_cfg_we_i==0): next state READ. mem_valid_o<=1, mem_addr_o<=granted address.
- Grant, port 1 config write: next state CFG. mem_cfgreg_we_o<=m1_cfg_we_i, mem_cfgreg_di_o<=m1_wdata_i. mem_valid_o stays 0.
- READ: mem_valid_o and mem_addr_o held stable. When mem_ready_i==1:
  - mem_valid_o<=0.
  - The granted port's rdata<=mem_rdata_i and its ready<=1.
  - Next state RESP.
- CFG: lasts exactly one cycle; mem_cfgreg_we_o is high only during it. Exit actions:
  - mem_cfgreg_we_o<=0.
  - m1_ready_o<=1, m1_rdata_o<=0.
  - Next state RESP.
- RESP: one cycle with ready high. All valids are ignored. Ready returns to 0 and state returns to IDLE.
- The non-granted port's ready stays 0 and its rdata keeps its last value.
- rdata holds between transactions.
- mem_ready_i is ignored outside READ.
- A requester that drops valid before its ready arrives is a protocol violation. The block completes the transaction anyway.

## Timing
- Cycle 0: request is seen in IDLE.
- Cycle 1: mem_valid_o (or mem_cfgreg_we_o) is high.
- Read latency: the ready pulse comes 1 cycle after the cycle in which mem_ready_i is sampled high.
- Config write: m1_ready_o is high in cycle 2.
- Minimum request spacing is 4 cycles for a read with a 1-cycle spimemio ready, and 3 cycles for a config write.
- Back-to-back contention alternates ports: worst-case wait is one foreign transaction.

## Configuration
- FLASH_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to READ and increments each READ cycle while mem_ready_i==0.
  - If mem_ready_i==1 arrives on the same cycle the count reaches TIMEOUT, the normal completion wins.
  - When the count reaches TIMEOUT without ready:
    - mem_valid_o<=0.
    - The granted port gets ready<=1 and rdata<=32'hFFFF_FFFF.
    - err_o<=1, cleared only by reset.
    - Next state RESP.
- FLASH_ARB_TIMEOUT_EN undefined: no counter; READ waits indefinitely; err_o is tied to 0.

## Test plan
- Reset with both valids high, then release: port 0 granted first. mem_valid_o=1, mem_addr_o=m0_addr_i one cycle after release. All outputs were 0 during reset.
- Port-0 read of 0x000100, with mem_ready_i pulsed and mem_rdata_i=0xA5A5_1234 three cycles later: m0_ready_o pulses once, one cycle later, with m0_rdata_o=0xA5A5_1234. m1_ready_o stays 0.
- Both ports continuously valid for 4 reads: mem_addr_o alternates m0, m1, m0, m1. Each port gets exactly 2 ready pulses.
- Port-1 config write, cfg_we=4'b1000, wdata=0x8000_0000: mem_cfgreg_we_o=4'b1000 for exactly one cycle. mem_cfgreg_di_o=0x8000_0000. mem_valid_o never asserts. m1_ready_o pulses next cycle with rdata 0.
- rstn_i asserted in the middle of READ: the next cycle is IDLE, mem_valid_o=0, no ready pulse, and port 0 is granted first afterwards.
- With FLASH_ARB_TIMEOUT_EN and TIMEOUT=16, mem_ready_i held 0: after 16 READ cycles mem_valid_o drops, m0_rdata_o=0xFFFF_FFFF with m0_ready_o pulse, and err_o stays 1 until reset.
